// File: rtl/scpad_tail_router.sv
// ---------------------------------------------------------------------------
// scpad_tail_router
//
// Scratchpad tail stage: steers completed read/write results from the stomach
// stage to one of NUM_SRC requester channels. Every channel owns an in-order
// response FIFO with its own valid/ready handshake, so a stalled consumer
// backpressures only its own channel. One instance per scratchpad bank.
//
// Parameters:
//   NUM_SRC    number of requester channels (0 = FE, 1 = BE, higher = extra)
//   DATA_W     read data width per response
//   FIFO_DEPTH entries per channel FIFO (power of two, >= 2)
//   SRC_W      width of the source id
//
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   in_valid    stomach result valid
//   in_ready    router accepts this cycle (depends only on FIFO state/in_src)
//   in_write    1 = write completion, 0 = read data
//   in_src      destination channel
//   in_rdata    read data (ignored for write completions)
//   out_valid   per-channel response valid
//   out_ready   per-channel consumer ready
//   out_write   per-channel write-completion flag
//   out_rdata   per-channel data, channel i at [i*DATA_W +: DATA_W]
//   bad_src     one-cycle pulse after an out-of-range result was dropped
//
// Optional feature (macro SCPAD_TAIL_STATS_EN):
//   stall_cnt   per-channel saturating 16-bit count of refused cycles
//   drop_cnt    saturating 16-bit count of out-of-range drops
// ---------------------------------------------------------------------------

// Checker: parameter sanity and output stability while a channel is stalled.
module scpad_tail_router_chk #(
  parameter int NUM_SRC    = 2,
  parameter int DATA_W     = 512,
  parameter int FIFO_DEPTH = 4
) (
  input logic                      clk,
  input logic                      rst,
  input logic [NUM_SRC-1:0]        out_valid,
  input logic [NUM_SRC-1:0]        out_ready,
  input logic [NUM_SRC-1:0]        out_write,
  input logic [NUM_SRC*DATA_W-1:0] out_rdata
);

  localparam bit DEPTH_OK = (FIFO_DEPTH >= 32'sd2) &&
                            ((FIFO_DEPTH & (FIFO_DEPTH - 32'sd1)) == 32'sd0);

  logic [NUM_SRC-1:0]        hold_r;
  logic [NUM_SRC-1:0]        write_q_r;
  logic [NUM_SRC*DATA_W-1:0] rdata_q_r;

  // FIFO geometry must allow pointer wrap with one extra lap bit.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (DEPTH_OK)
        else $error("scpad_tail_router: FIFO_DEPTH must be a power of two >= 2");
    end
  end

  // Remember which channels were stalled last cycle and what they showed.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_r <= {NUM_SRC{1'b0}};
    end else begin
      hold_r <= out_valid & ~out_ready;
    end
    write_q_r <= out_write;
    rdata_q_r <= out_rdata;
  end

  // A stalled response must stay valid and unchanged until it is taken.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_SRC; i++) begin
      if (!rst && hold_r[i]) begin
        assert (out_valid[i] && (out_write[i] == write_q_r[i]) &&
                (out_rdata[i*DATA_W +: DATA_W] == rdata_q_r[i*DATA_W +: DATA_W]))
          else $error("scpad_tail_router: channel %0d changed while stalled", i);
      end
    end
  end

endmodule

// Router top.
module scpad_tail_router #(
  parameter int NUM_SRC    = 2,
  parameter int DATA_W     = 512,
  parameter int FIFO_DEPTH = 4,
  parameter int SRC_W      = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      in_write,
  input  logic [SRC_W-1:0]          in_src,
  input  logic [DATA_W-1:0]         in_rdata,
  output logic [NUM_SRC-1:0]        out_valid,
  input  logic [NUM_SRC-1:0]        out_ready,
  output logic [NUM_SRC-1:0]        out_write,
  output logic [NUM_SRC*DATA_W-1:0] out_rdata,
`ifdef SCPAD_TAIL_STATS_EN
  output logic [NUM_SRC*16-1:0]     stall_cnt,
  output logic [15:0]               drop_cnt,
`endif
  output logic                      bad_src
);

  localparam int PTR_W = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam int ENT_W = DATA_W + 1;
  localparam logic [PTR_W:0] PTR_ONE = {{PTR_W{1'b0}}, 1'b1};

  logic [NUM_SRC-1:0] hit_s;
  logic [NUM_SRC-1:0] full_s;
  logic [NUM_SRC-1:0] push_s;
  logic               accept_s;
  logic               drop_s;
  logic [ENT_W-1:0]   push_ent_s;
  logic               bad_src_r;

  // in_ready looks only at the addressed FIFO's full flag; out_ready never
  // enters this path, so a full FIFO refuses even when it pops this cycle.
  // An out-of-range source hits no channel and is always accepted.
  assign in_ready = ~|(hit_s & full_s);
  assign accept_s = in_valid & in_ready;
  assign push_s   = hit_s & {NUM_SRC{accept_s}};
  assign drop_s   = accept_s & ~|hit_s;
  assign bad_src  = bad_src_r;

  // Build the stored entry {write, rdata}; write completions carry zero data.
  always_comb begin
    if (in_write) begin
      push_ent_s = {1'b1, {DATA_W{1'b0}}};
    end else begin
      push_ent_s = {1'b0, in_rdata};
    end
  end

  // Out-of-range pulse, high for exactly the cycle after the drop.
  always_ff @(posedge clk) begin
    if (rst) begin
      bad_src_r <= 1'b0;
    end else begin
      bad_src_r <= drop_s;
    end
  end

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_ch
    logic [ENT_W-1:0] mem_r [FIFO_DEPTH];
    logic [PTR_W:0]   wr_ptr_r;
    logic [PTR_W:0]   rd_ptr_r;
    logic [PTR_W:0]   wr_ptr_s;
    logic [PTR_W:0]   rd_ptr_s;
    logic             valid_r;
    logic [ENT_W-1:0] head_r;
    logic [ENT_W-1:0] head_s;
    logic             pop_s;
    logic             empty_s;

    assign hit_s[g]  = (in_src == SRC_W'(g));
    // Same slot, different lap bit: the writer is a full lap ahead.
    assign full_s[g] = (wr_ptr_r[PTR_W] != rd_ptr_r[PTR_W]) &&
                       (wr_ptr_r[PTR_W-1:0] == rd_ptr_r[PTR_W-1:0]);
    // valid_r always equals "FIFO non-empty", so it doubles as the pop gate.
    assign pop_s     = valid_r & out_ready[g];

    // Next pointers and the entry that will sit at the head next cycle, so
    // the output registers can be loaded directly with it.
    always_comb begin
      if (push_s[g]) begin
        wr_ptr_s = wr_ptr_r + PTR_ONE;
      end else begin
        wr_ptr_s = wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_s = rd_ptr_r + PTR_ONE;
      end else begin
        rd_ptr_s = rd_ptr_r;
      end
      empty_s = (wr_ptr_s == rd_ptr_s);
      if (empty_s) begin
        head_s = {ENT_W{1'b0}};
      end else if (push_s[g] && (rd_ptr_s == wr_ptr_r)) begin
        // The slot being written this cycle becomes the head.
        head_s = push_ent_s;
      end else begin
        head_s = mem_r[rd_ptr_s[PTR_W-1:0]];
      end
    end

    // Entry storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
      if (push_s[g]) begin
        mem_r[wr_ptr_r[PTR_W-1:0]] <= push_ent_s;
      end
    end

    // Pointers and registered head/valid outputs.
    always_ff @(posedge clk) begin
      if (rst) begin
        wr_ptr_r <= {(PTR_W+1){1'b0}};
        rd_ptr_r <= {(PTR_W+1){1'b0}};
        valid_r  <= 1'b0;
        head_r   <= {ENT_W{1'b0}};
      end else begin
        wr_ptr_r <= wr_ptr_s;
        rd_ptr_r <= rd_ptr_s;
        valid_r  <= ~empty_s;
        head_r   <= head_s;
      end
    end

    assign out_valid[g]                  = valid_r;
    assign out_write[g]                  = head_r[DATA_W];
    assign out_rdata[g*DATA_W +: DATA_W] = head_r[DATA_W-1:0];

`ifdef SCPAD_TAIL_STATS_EN
    logic [15:0] stall_r;

    // Cycles in which a result for this channel was presented but refused.
    always_ff @(posedge clk) begin
      if (rst) begin
        stall_r <= 16'h0000;
      end else if (in_valid && hit_s[g] && !in_ready && (stall_r != 16'hFFFF)) begin
        stall_r <= stall_r + 16'h0001;
      end
    end

    assign stall_cnt[g*16 +: 16] = stall_r;
`endif
  end

`ifdef SCPAD_TAIL_STATS_EN
  logic [15:0] drop_r;

  // Out-of-range drops, saturating.
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_r <= 16'h0000;
    end else if (drop_s && (drop_r != 16'hFFFF)) begin
      drop_r <= drop_r + 16'h0001;
    end
  end

  assign drop_cnt = drop_r;
`endif

  scpad_tail_router_chk #(
    .NUM_SRC    (NUM_SRC),
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_chk (
    .clk       (clk),
    .rst       (rst),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_write (out_write),
    .out_rdata (out_rdata)
  );

endmodule

// File: tb/tb_scpad_tail_router.sv
// Bench for scpad_tail_router: three channels, 64-bit data, depth 4.
// A per-channel queue/count model predicts in_ready, out_valid, head data
// and bad_src every cycle; scenario tasks add targeted inline checks.
module tb_scpad_tail_router;

  localparam int NUM_SRC    = 3;
  localparam int DATA_W     = 64;
  localparam int FIFO_DEPTH = 4;
  localparam int SRC_W      = 2;

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      in_valid;
  logic                      in_ready;
  logic                      in_write;
  logic [SRC_W-1:0]          in_src;
  logic [DATA_W-1:0]         in_rdata;
  logic [NUM_SRC-1:0]        out_valid;
  logic [NUM_SRC-1:0]        out_ready;
  logic [NUM_SRC-1:0]        out_write;
  logic [NUM_SRC*DATA_W-1:0] out_rdata;
  logic                      bad_src;
`ifdef SCPAD_TAIL_STATS_EN
  logic [NUM_SRC*16-1:0]     stall_cnt;
  logic [15:0]               drop_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  logic [DATA_W:0] exp_q [NUM_SRC][$];
  int              cnt   [NUM_SRC];
  logic            bad_exp = 1'b0;

  always #5 clk = ~clk;

  scpad_tail_router #(
    .NUM_SRC    (NUM_SRC),
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH),
    .SRC_W      (SRC_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_write  (in_write),
    .in_src    (in_src),
    .in_rdata  (in_rdata),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_write (out_write),
    .out_rdata (out_rdata),
`ifdef SCPAD_TAIL_STATS_EN
    .stall_cnt (stall_cnt),
    .drop_cnt  (drop_cnt),
`endif
    .bad_src   (bad_src)
  );

  // One clock: sample at negedge against the model, update the model with the
  // handshakes that the coming posedge will perform, then return at posedge+1.
  task automatic tick();
    logic [NUM_SRC-1:0] exp_valid;
    logic               exp_ready;
    logic               oor;
    int                 idx;
    logic [DATA_W:0]    head;
    @(negedge clk);
    idx = int'(in_src);
    oor = (idx >= NUM_SRC);
    if (oor) exp_ready = 1'b1;
    else     exp_ready = (cnt[idx] < FIFO_DEPTH);
    for (int ch = 0; ch < NUM_SRC; ch++) exp_valid[ch] = (cnt[ch] != 0);
    n_checks++;
    if (out_valid !== exp_valid) begin
      n_errors++; $display("FAIL sb_out_valid got %b want %b @%0t", out_valid, exp_valid, $time);
    end
    n_checks++;
    if (in_ready !== exp_ready) begin
      n_errors++; $display("FAIL sb_in_ready src %0d got %b want %b @%0t", idx, in_ready, exp_ready, $time);
    end
    n_checks++;
    if (bad_src !== bad_exp) begin
      n_errors++; $display("FAIL sb_bad_src got %b want %b @%0t", bad_src, bad_exp, $time);
    end
    for (int ch = 0; ch < NUM_SRC; ch++) begin
      if (exp_valid[ch]) begin
        head = exp_q[ch][0];
        n_checks++;
        if ({out_write[ch], out_rdata[ch*DATA_W +: DATA_W]} !== head) begin
          n_errors++;
          $display("FAIL sb_head ch%0d got w=%b d=%h want w=%b d=%h @%0t", ch, out_write[ch],
                   out_rdata[ch*DATA_W +: DATA_W], head[DATA_W], head[DATA_W-1:0], $time);
        end
        if (out_ready[ch]) begin
          void'(exp_q[ch].pop_front());
          cnt[ch]--;
        end
      end
    end
    if (rst) begin
      for (int ch = 0; ch < NUM_SRC; ch++) begin
        exp_q[ch].delete();
        cnt[ch] = 0;
      end
      bad_exp = 1'b0;
    end else begin
      if (in_valid && exp_ready && !oor) begin
        exp_q[idx].push_back(in_write ? {1'b1, {DATA_W{1'b0}}} : {1'b0, in_rdata});
        cnt[idx]++;
      end
      bad_exp = in_valid && oor;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_write = 1'b0; in_src = 2'd0;
    in_rdata = 64'h0; out_ready = 3'b000;
    tick();
    n_checks++; if (out_valid !== 3'b000) begin n_errors++; $display("FAIL reset_valid got %b want 000", out_valid); end
    n_checks++; if (out_write !== 3'b000) begin n_errors++; $display("FAIL reset_write got %b want 000", out_write); end
    n_checks++; if (out_rdata !== {(NUM_SRC*DATA_W){1'b0}}) begin n_errors++; $display("FAIL reset_rdata got %h want 0", out_rdata); end
    n_checks++; if (bad_src !== 1'b0) begin n_errors++; $display("FAIL reset_bad_src got %b want 0", bad_src); end
    n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
`ifdef SCPAD_TAIL_STATS_EN
    n_checks++; if (drop_cnt !== 16'h0) begin n_errors++; $display("FAIL reset_drop_cnt got %h want 0", drop_cnt); end
    n_checks++; if (stall_cnt !== {(NUM_SRC*16){1'b0}}) begin n_errors++; $display("FAIL reset_stall_cnt got %h want 0", stall_cnt); end
`endif
    rst = 1'b0;
  endtask

  task automatic test_read_src0();
    in_valid = 1'b1; in_write = 1'b0; in_src = 2'd0; in_rdata = 64'hA5A5_A5A5_A5A5_A5A5;
    tick();
    in_valid = 1'b0;
    n_checks++; if (out_valid !== 3'b001) begin n_errors++; $display("FAIL read_valid got %b want 001", out_valid); end
    n_checks++; if (out_rdata[63:0] !== 64'hA5A5_A5A5_A5A5_A5A5) begin n_errors++; $display("FAIL read_data got %h want a5a5a5a5a5a5a5a5", out_rdata[63:0]); end
    n_checks++; if (out_write[0] !== 1'b0) begin n_errors++; $display("FAIL read_write got %b want 0", out_write[0]); end
    out_ready = 3'b001;
    tick();
    n_checks++; if (out_valid !== 3'b000) begin n_errors++; $display("FAIL read_pop got %b want 000", out_valid); end
    out_ready = 3'b000;
  endtask

  task automatic test_write_src1();
    in_valid = 1'b1; in_write = 1'b1; in_src = 2'd1; in_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    in_valid = 1'b0; in_write = 1'b0;
    n_checks++; if (out_valid[1] !== 1'b1) begin n_errors++; $display("FAIL wr_valid got %b want 1", out_valid[1]); end
    n_checks++; if (out_write[1] !== 1'b1) begin n_errors++; $display("FAIL wr_flag got %b want 1", out_write[1]); end
    n_checks++; if (out_rdata[127:64] !== 64'h0) begin n_errors++; $display("FAIL wr_zero_data got %h want 0", out_rdata[127:64]); end
    out_ready = 3'b010;
    tick();
    n_checks++; if (out_valid[1] !== 1'b0) begin n_errors++; $display("FAIL wr_pop got %b want 0", out_valid[1]); end
    out_ready = 3'b000;
  endtask

  task automatic test_backpressure();
    out_ready = 3'b000; in_write = 1'b0; in_src = 2'd0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_rdata = 64'h1000 + 64'(i);
      tick();
    end
    n_checks++; if (in_ready !== 1'b0) begin n_errors++; $display("FAIL bp_full_ready got %b want 0", in_ready); end
    in_src = 2'd1; out_ready = 3'b010;
    for (int i = 0; i < 2; i++) begin
      in_rdata = 64'h2000 + 64'(i);
      tick();
    end
    in_valid = 1'b0;
    tick();
    n_checks++; if (out_valid !== 3'b001) begin n_errors++; $display("FAIL bp_independent got %b want 001", out_valid); end
    out_ready = 3'b001;
    repeat (4) tick();
    n_checks++; if (out_valid !== 3'b000) begin n_errors++; $display("FAIL bp_drain got %b want 000", out_valid); end
    out_ready = 3'b000;
  endtask

  task automatic test_full_pop_push();
    out_ready = 3'b000; in_write = 1'b0; in_src = 2'd0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_rdata = 64'h3000 + 64'(i);
      tick();
    end
    in_rdata = 64'h3004; out_ready = 3'b001;
    n_checks++; if (in_ready !== 1'b0) begin n_errors++; $display("FAIL fpp_refuse got %b want 0", in_ready); end
    tick();
    n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL fpp_retry got %b want 1", in_ready); end
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    n_checks++; if (out_valid !== 3'b000) begin n_errors++; $display("FAIL fpp_drain got %b want 000", out_valid); end
    out_ready = 3'b000;
  endtask

  task automatic test_bad_src();
    in_valid = 1'b1; in_write = 1'b0; in_src = 2'd3; in_rdata = 64'hDEAD_BEEF_0BAD_F00D;
    n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL bad_ready got %b want 1", in_ready); end
    tick();
    in_valid = 1'b0;
    n_checks++; if (bad_src !== 1'b1) begin n_errors++; $display("FAIL bad_pulse got %b want 1", bad_src); end
    n_checks++; if (out_valid !== 3'b000) begin n_errors++; $display("FAIL bad_no_push got %b want 000", out_valid); end
`ifdef SCPAD_TAIL_STATS_EN
    n_checks++; if (drop_cnt !== 16'd1) begin n_errors++; $display("FAIL bad_drop_cnt got %0d want 1", drop_cnt); end
`endif
    tick();
    n_checks++; if (bad_src !== 1'b0) begin n_errors++; $display("FAIL bad_one_cycle got %b want 0", bad_src); end
  endtask

  task automatic test_reset_mid();
    out_ready = 3'b000; in_write = 1'b0; in_valid = 1'b1;
    in_src = 2'd0; in_rdata = 64'h5000; tick();
    in_src = 2'd0; in_rdata = 64'h5001; tick();
    in_src = 2'd2; in_rdata = 64'h5002; tick();
    in_valid = 1'b0;
    n_checks++; if (out_valid !== 3'b101) begin n_errors++; $display("FAIL mid_buffered got %b want 101", out_valid); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++; if (out_valid !== 3'b000) begin n_errors++; $display("FAIL mid_flush got %b want 000", out_valid); end
    in_valid = 1'b1; in_src = 2'd1; in_rdata = 64'h4444;
    tick();
    in_valid = 1'b0;
    n_checks++; if (out_valid !== 3'b010) begin n_errors++; $display("FAIL mid_new_valid got %b want 010", out_valid); end
    n_checks++; if (out_rdata[127:64] !== 64'h4444) begin n_errors++; $display("FAIL mid_new_data got %h want 4444", out_rdata[127:64]); end
    out_ready = 3'b010;
    tick();
    out_ready = 3'b000;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 300; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_src    = 2'($urandom_range(0, 3));
      in_write  = ($urandom_range(0, 2) == 0);
      in_rdata  = {$urandom, $urandom};
      out_ready = 3'($urandom);
      tick();
    end
    in_valid = 1'b0; out_ready = 3'b111;
    repeat (6) tick();
    n_checks++; if (out_valid !== 3'b000) begin n_errors++; $display("FAIL b2b_drain got %b want 000", out_valid); end
  endtask

  initial begin
    for (int ch = 0; ch < NUM_SRC; ch++) cnt[ch] = 0;
    rst = 1'b1; in_valid = 1'b0; in_write = 1'b0; in_src = 2'd0;
    in_rdata = 64'h0; out_ready = 3'b000;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_read_src0();
    test_write_src1();
    test_backpressure();
    test_full_pop_push();
    test_bad_src();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/scpad_tail_router.md
Name: scpad_tail_router

Overview:
- Parametrised successor to the scratchpad tail stage. It takes completed read/write results from the stomach stage and steers each one to one of NUM_SRC requesters: frontend, backend, and any added DMA or tensor-core ports.
- Each requester gets its own response FIFO with a valid/ready handshake, so a stalled consumer backpressures only its own channel.
- Sits between the stomach stage and the requester response buses, one instance per scratchpad bank (SCPAD_ID).

Parameters:
- NUM_SRC, 2, number of requester channels (0 = FE, 1 = BE, higher = extra ports); min 1.
- DATA_W, 512, width of rdata per response.
- FIFO_DEPTH, 4, entries per channel FIFO; power of two, min 2.
- SRC_W, $clog2(NUM_SRC) (min 1), width of the source id.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  stomach result valid.
- in_ready  out  1  router accepts this cycle.
- in_write  in  1  1 = write completion, 0 = read data.
- in_src  in  SRC_W  destination channel.
- in_rdata  in  DATA_W  read data; ignored when in_write = 1.
- out_valid  out  NUM_SRC  per-channel response valid.
- out_ready  in  NUM_SRC  per-channel consumer ready.
- out_write  out  NUM_SRC  per-channel write-completion flag.
- out_rdata  out  NUM_SRC*DATA_W  per-channel data; channel i occupies bits [i*DATA_W +: DATA_W].
- bad_src  out  1  one-cycle pulse when a result with in_src >= NUM_SRC is accepted.

Behaviour:
- One clock domain. Reset is synchronous and active-high: clk is the clock, rst the reset.
- Reset values:
  - All FIFOs empty and all pointers 0.
  - out_valid = 0, out_write = 0, out_rdata = 0, bad_src = 0.
  - in_ready reflects the empty FIFOs.
- Handshake:
  - Transfer in occurs when in_valid && in_ready.
  - Transfer out on channel i occurs when out_valid[i] && out_ready[i].
- Acceptance:
  - in_ready = !full[in_src] when in_src < NUM_SRC.
  - in_ready = 1 for an out-of-range in_src.
  - in_ready never depends on out_ready; there is no combinational out_ready to in_ready path.
  - A full FIFO refuses a push even if it pops that same cycle.
- Push: stores {write, rdata}. For write completions the stored rdata is forced to 0.
- Out-of-range src:
  - The result is consumed and dropped, and no FIFO changes.
  - bad_src is registered high for exactly the following cycle.
- Latency: a result accepted in cycle N gives out_valid = 1 in cycle N+1 at the earliest. out_* are driven from the FIFO head register (registered outputs).
- Stability: while out_valid[i] = 1 and out_ready[i] = 0, out_write[i] and out_rdata[i] hold stable.
- Ordering: in-order within a channel; channels are independent.
- Simultaneous push and pop on a non-full channel: both happen and the count is unchanged.
- Empty channel with out_ready = 1: no pop, out_valid stays 0.
- Pointers wrap modulo FIFO_DEPTH. Full and empty are distinguished with an extra pointer bit.
- Reset mid-operation: all buffered entries are discarded and outputs return to reset values on the next edge.
- Parameter check: an assertion fires if FIFO_DEPTH is not a power of two or is below 2.

Optional Feature:
- Macro name: SCPAD_TAIL_STATS_EN.
- With the macro defined, the block adds the following outputs:
  - stall_cnt: NUM_SRC*16, one saturating counter per channel, incremented each cycle with in_valid && in_src == i && !in_ready.
  - drop_cnt: 16, saturating count of bad_src events.
  - Both counters reset to 0 and stick at 16'hFFFF.
- Without the macro: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset, then read to src 0 with rdata 0xA5.. → next cycle out_valid = 2'b01, out_rdata[0] = 0xA5.., out_write[0] = 0; pop clears it.
- Write completion to src 1 with in_rdata = all ones → out_valid[1] = 1, out_write[1] = 1, out_rdata[1] = 0.
- Hold out_ready[0] = 0 and push 4 results to src 0 (FIFO_DEPTH 4) → in_ready drops to 0 for src 0. Results to src 1 are still accepted and delivered. Releasing out_ready drains 4 entries in order.
- Full channel 0 with simultaneous pop and push attempt → push refused that cycle and accepted the next cycle; order preserved.
- NUM_SRC = 3, in_src = 3 → in_ready = 1, bad_src pulses for one cycle, no out_valid change. With SCPAD_TAIL_STATS_EN, drop_cnt = 1.
- Assert rst with 3 entries buffered → next cycle all out_valid = 0, and a new push is delivered after 1 cycle.
